// File: rtl/bit_presence_store_pkg.sv
// Shared widths and state encoding for the bit-presence store.
package bit_presence_store_pkg;

    localparam int unsigned DEFAULT_LETTER_INDEX_BITS = 4;
    localparam int unsigned DEFAULT_WORD_INDEX_BITS   = 6;
    localparam int unsigned DEFAULT_ADDRESS_BITS      =
        DEFAULT_LETTER_INDEX_BITS + DEFAULT_WORD_INDEX_BITS;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } storeState_t;

endpackage

// File: rtl/address_counter.sv
// Free-running address generator, enabled once storage has been cleared.
module address_counter
    import bit_presence_store_pkg::*;
#(
    parameter int unsigned LETTERINDEXBITS = DEFAULT_LETTER_INDEX_BITS,
    parameter int unsigned WORDINDEXBITS   = DEFAULT_WORD_INDEX_BITS
) (
    input  logic                                     clock,
    input  logic                                     clearStorage,
    input  logic                                     storageReady,
    output logic [LETTERINDEXBITS+WORDINDEXBITS-1:0] address,
    output logic                                     newAddress
);

    localparam int unsigned ADDRESSBITS = LETTERINDEXBITS + WORDINDEXBITS;

    logic [ADDRESSBITS-1:0] counter;

    // Counter wraps naturally at 2^ADDRESSBITS.
    always_ff @(posedge clock) begin
        if (clearStorage) begin
            counter    <= '0;
            address    <= '0;
            newAddress <= 1'b0;
        end else if (storageReady) begin
            address    <= counter;
            newAddress <= 1'b1;
            counter    <= counter + ADDRESSBITS'(1);
        end else begin
            newAddress <= 1'b0;
        end
    end

endmodule

// File: rtl/address_splitter.sv
// Registers the word/letter split of the current address plus its valid flag.
module address_splitter
    import bit_presence_store_pkg::*;
#(
    parameter int unsigned LETTERINDEXBITS = DEFAULT_LETTER_INDEX_BITS,
    parameter int unsigned WORDINDEXBITS   = DEFAULT_WORD_INDEX_BITS
) (
    input  logic                                     clock,
    input  logic                                     clearStorage,
    input  logic [LETTERINDEXBITS+WORDINDEXBITS-1:0] address,
    input  logic                                     newAddress,
    output logic [WORDINDEXBITS-1:0]                 wordIndex,
    output logic [LETTERINDEXBITS-1:0]               letterIndex,
    output logic                                     addressValid
);

    localparam int unsigned ADDRESSBITS = LETTERINDEXBITS + WORDINDEXBITS;

    always_ff @(posedge clock) begin
        if (clearStorage) begin
            wordIndex    <= '0;
            letterIndex  <= '0;
            addressValid <= 1'b0;
        end else begin
            wordIndex    <= address[WORDINDEXBITS-1:0];
            letterIndex  <= address[ADDRESSBITS-1:WORDINDEXBITS];
            addressValid <= newAddress;
        end
    end

endmodule

// File: rtl/bit_storage.sv
// Row-organised bit array with a row-at-a-time clear sweep, set-only write and one read port.
module bit_storage
    import bit_presence_store_pkg::*;
#(
    parameter int unsigned LETTERINDEXBITS = DEFAULT_LETTER_INDEX_BITS,
    parameter int unsigned WORDINDEXBITS   = DEFAULT_WORD_INDEX_BITS
) (
    input  logic                       clock,
    input  logic                       clearStorage,
    input  logic                       addressValid,
    input  logic [WORDINDEXBITS-1:0]   wordIndex,
    input  logic [LETTERINDEXBITS-1:0] letterIndex,
    input  logic                       inquiry,
    input  logic [WORDINDEXBITS-1:0]   inquiryWordIndex,
    input  logic [LETTERINDEXBITS-1:0] inquiryLetterIndex,
    output logic                       storageReady,
    output logic                       readReady,
    output logic                       storedValue
);

    localparam int unsigned ROWS    = 2 ** WORDINDEXBITS;
    localparam int unsigned ROWBITS = 2 ** LETTERINDEXBITS;

    storeState_t              state;
    storeState_t              nextState;
    logic [WORDINDEXBITS-1:0] clearPtr;
    logic                     lastRow;
    logic                     writeEnable;
    logic [ROWBITS-1:0]       rows [ROWS];

    always_ff @(posedge clock) begin
        if (clearStorage) begin
            state <= CLEAR;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState   = state;
        lastRow     = 1'b0;
        writeEnable = 1'b0;
        case (state)
            CLEAR: begin
                lastRow = (clearPtr == WORDINDEXBITS'(ROWS - 1));
                if (lastRow) begin
                    nextState = RUN;
                end
            end
            RUN: begin
                writeEnable = addressValid;
            end
            default: nextState = CLEAR;
        endcase
    end

    // Control, clear pointer and read port; reads see the array before this edge's write.
    always_ff @(posedge clock) begin
        if (clearStorage) begin
            clearPtr     <= '0;
            storageReady <= 1'b0;
            readReady    <= 1'b0;
            storedValue  <= 1'b0;
        end else begin
            if (state == CLEAR) begin
                clearPtr <= clearPtr + WORDINDEXBITS'(1);
                if (lastRow) begin
                    storageReady <= 1'b1;
                end
            end
            readReady <= inquiry && storageReady;
            if (inquiry && storageReady) begin
                storedValue <= rows[inquiryWordIndex][inquiryLetterIndex];
            end
        end
    end

    // The array itself carries no reset; the clear sweep zeroes it row by row.
    always_ff @(posedge clock) begin
        if (!clearStorage) begin
            if (state == CLEAR) begin
                rows[clearPtr] <= '0;
            end else if (writeEnable) begin
                rows[wordIndex][letterIndex] <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/bit_presence_store.sv
// Address sweep feeding a bit-presence array, with an external query port.
module bit_presence_store
    import bit_presence_store_pkg::*;
#(
    parameter int unsigned LETTERINDEXBITS = DEFAULT_LETTER_INDEX_BITS,
    parameter int unsigned WORDINDEXBITS   = DEFAULT_WORD_INDEX_BITS
) (
    input  logic                                     clock,
    input  logic                                     clearStorage,
    input  logic                                     inquiry,
    input  logic [WORDINDEXBITS-1:0]                 inquiryWordIndex,
    input  logic [LETTERINDEXBITS-1:0]               inquiryLetterIndex,
    output logic                                     storageReady,
    output logic [LETTERINDEXBITS+WORDINDEXBITS-1:0] address,
    output logic                                     newAddress,
    output logic [WORDINDEXBITS-1:0]                 wordIndex,
    output logic [LETTERINDEXBITS-1:0]               letterIndex,
    output logic                                     readReady,
    output logic                                     storedValue
);

    logic addressValid;

    address_counter #(
        .LETTERINDEXBITS(LETTERINDEXBITS),
        .WORDINDEXBITS  (WORDINDEXBITS)
    ) counterInst (
        .clock       (clock),
        .clearStorage(clearStorage),
        .storageReady(storageReady),
        .address     (address),
        .newAddress  (newAddress)
    );

    address_splitter #(
        .LETTERINDEXBITS(LETTERINDEXBITS),
        .WORDINDEXBITS  (WORDINDEXBITS)
    ) splitterInst (
        .clock       (clock),
        .clearStorage(clearStorage),
        .address     (address),
        .newAddress  (newAddress),
        .wordIndex   (wordIndex),
        .letterIndex (letterIndex),
        .addressValid(addressValid)
    );

    bit_storage #(
        .LETTERINDEXBITS(LETTERINDEXBITS),
        .WORDINDEXBITS  (WORDINDEXBITS)
    ) storageInst (
        .clock             (clock),
        .clearStorage      (clearStorage),
        .addressValid      (addressValid),
        .wordIndex         (wordIndex),
        .letterIndex       (letterIndex),
        .inquiry           (inquiry),
        .inquiryWordIndex  (inquiryWordIndex),
        .inquiryLetterIndex(inquiryLetterIndex),
        .storageReady      (storageReady),
        .readReady         (readReady),
        .storedValue       (storedValue)
    );

endmodule

// File: tb/tb_bit_presence_store.sv
// Randomised scoreboard bench for bit_presence_store against an edge-indexed reference model.
module tb_bit_presence_store;

    localparam int LB    = 4;
    localparam int WB    = 6;
    localparam int ROWS  = 64;
    localparam int LETTERS = 16;
    localparam int ADDRS = 1024;

    logic          clock = 1'b0;
    logic          clearStorage = 1'b0;
    logic          inquiry = 1'b0;
    logic [WB-1:0] inquiryWordIndex = '0;
    logic [LB-1:0] inquiryLetterIndex = '0;
    logic          storageReady;
    logic [LB+WB-1:0] address;
    logic          newAddress;
    logic [WB-1:0] wordIndex;
    logic [LB-1:0] letterIndex;
    logic          readReady;
    logic          storedValue;

    always #5 clock = ~clock;

    bit_presence_store dut (
        .clock             (clock),
        .clearStorage      (clearStorage),
        .inquiry           (inquiry),
        .inquiryWordIndex  (inquiryWordIndex),
        .inquiryLetterIndex(inquiryLetterIndex),
        .storageReady      (storageReady),
        .address           (address),
        .newAddress        (newAddress),
        .wordIndex         (wordIndex),
        .letterIndex       (letterIndex),
        .readReady         (readReady),
        .storedValue       (storedValue)
    );

    typedef struct {
        int edgeNum;
        int w;
        int l;
        bit value;
    } expect_t;

    expect_t expectQ[$];
    int      errors = 0;
    int      checks = 0;
    int      globalEdge = 0;
    int      k = 0;
    bit      monitorOn = 1'b0;
    bit      modelBits[ADDRS];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d since clear)", name, act, req, k);
        end
    endtask

    always @(posedge clock) globalEdge <= globalEdge + 1;

    // Monitor: each negedge, a read result is due exactly when the oldest expectation matches this edge.
    always @(negedge clock) begin
        if (monitorOn) begin
            if (expectQ.size() != 0 && expectQ[0].edgeNum == globalEdge) begin
                expect_t e;
                e = expectQ.pop_front();
                check("readReady", int'(readReady === 1'b1), 1);
                check($sformatf("storedValue w%0d l%0d", e.w, e.l), int'(storedValue === 1'b1), int'(e.value));
            end else begin
                check("readReady idle", int'(readReady !== 1'b0), 0);
            end
        end
    end

    // One clock of stimulus; the model says what the DUT must hold after the edge.
    task automatic cyc(input bit clr, input bit inq, input int w, input int l);
        int expAddr;
        int splitAddr;
        @(negedge clock);
        clearStorage       = clr;
        inquiry            = inq;
        inquiryWordIndex   = WB'(w);
        inquiryLetterIndex = LB'(l);
        if (clr) begin
            k = 0;
            foreach (modelBits[i]) modelBits[i] = 1'b0;
        end else begin
            k++;
        end
        if (inq && !clr && k >= ROWS + 1)
            expectQ.push_back('{edgeNum: globalEdge + 1, w: w, l: l, value: modelBits[l * ROWS + w]});
        if (!clr && k >= ROWS + 3)
            modelBits[(k - (ROWS + 3)) % ADDRS] = 1'b1;
        @(posedge clock);
        #1;
        expAddr   = (k >= ROWS + 1) ? (k - (ROWS + 1)) % ADDRS : 0;
        splitAddr = (k >= ROWS + 2) ? (k - (ROWS + 2)) % ADDRS : 0;
        check("storageReady", int'(storageReady === 1'b1), int'(k >= ROWS));
        check("newAddress", int'(newAddress === 1'b1), int'(k >= ROWS + 1));
        check("address", int'(address), expAddr);
        check("wordIndex", int'(wordIndex), splitAddr % ROWS);
        check("letterIndex", int'(letterIndex), splitAddr / ROWS);
        monitorOn = 1'b1;
    endtask

    task automatic rndCyc();
        cyc(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, ROWS - 1)),
            int'($urandom_range(0, LETTERS - 1)));
    endtask

    // Random cycles until the next cyc call lands on edge 'target'.
    task automatic runUntil(input int target);
        while (k < target - 1) rndCyc();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc(1'b1, 1'b0, 0, 0);
        runUntil(ROWS + 1);
        cyc(1'b0, 1'b1, 5, 3);
        runUntil(264);
        cyc(1'b0, 1'b1, 5, 3);
        cyc(1'b0, 1'b1, 5, 3);
        cyc(1'b0, 1'b1, 5, 3);
        runUntil(268);
        cyc(1'b0, 1'b1, 5, 3);
        cyc(1'b0, 1'b1, 63, 15);
        runUntil(500);
        cyc(1'b1, 1'b1, 5, 3);
        runUntil(ROWS + 1);
        cyc(1'b0, 1'b1, 5, 3);
        for (int i = 0; i < 20; i++) rndCyc();
        cyc(1'b0, 1'b1, 5, 3);
        runUntil(1100);
        for (int idx = 0; idx < ADDRS; idx++)
            cyc(1'b0, 1'b1, idx % ROWS, idx / ROWS);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 0, 0);
        check("scoreboard drained", expectQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
